// File: rtl/instr_mem_server.sv
// instr_mem_server: 24-bit instruction memory for the CPU fetch stage with a
// host-side byte loader that writes the program image.
//
// Ports:
//   iclk, irst          clock, synchronous active-high reset
//   iLoadStart          pulse: begin (or restart) a program load
//   iLoadValid/iLoadByte/iLoadLast
//                       host byte stream, little-endian within each word,
//                       iLoadLast marks the final byte of the image
//   oLoadReady          loader accepts a byte this cycle (LOAD state)
//   iInstrAddr          fetch byte address (PC steps of 3)
//   oInstr              fetched word, one cycle after the address
//   oCpuRun             image complete, CPU may run
//   oAddrFault          last fetch misaligned or beyond the loaded image
//   oOverflow           sticky: image longer than DEPTH words
//   oWordCount          words written by the last or current load
//   oChecksum           running XOR of accepted bytes when the optional
//                       feature is built, otherwise 8'h00
//
// Build option: define INSTR_MEM_CHECKSUM_EN to generate the checksum logic.
module instr_mem_server #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iLoadStart,
  input  logic             iLoadValid,
  input  logic [7:0]       iLoadByte,
  input  logic             iLoadLast,
  output logic             oLoadReady,
  input  logic [15:0]      iInstrAddr,
  output logic [23:0]      oInstr,
  output logic             oCpuRun,
  output logic             oAddrFault,
  output logic             oOverflow,
  output logic [IDX_W:0]   oWordCount,
  output logic [7:0]       oChecksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  state_t         state, nextState;
  logic [1:0]     lane;
  logic [15:0]    pack;
  logic [IDX_W:0] wordCount;
  logic           overflow;
  logic [23:0]    mem [DEPTH];

  logic           accept;
  logic           wordEnd;
  logic           full;
  logic           memWe;
  logic [23:0]    wordData;
  logic [15:0]    fetchIdx;
  logic           aligned;
  logic           inImage;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    oLoadReady = 1'b0;
    oCpuRun    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (iLoadStart) nextState = LOAD;
      end
      LOAD: begin
        oLoadReady = 1'b1;
        // A restart wins over a byte offered in the same cycle.
        accept = iLoadValid && !iLoadStart;
        if (accept && iLoadLast) nextState = DONE;
      end
      DONE: begin
        oCpuRun = 1'b1;
        if (iLoadStart) nextState = LOAD;
      end
      default: nextState = IDLE;
    endcase
  end

  // ------------------------------------------------------ word assembly
  always_comb begin
    wordEnd = accept && ((lane == 2'd2) || iLoadLast);
    full    = (wordCount == DEPTH_CNT);
    memWe   = wordEnd && !full;
    // A short final word is zero-padded in its upper lanes.
    case (lane)
      2'd0:    wordData = {16'h0000, iLoadByte};
      2'd1:    wordData = {8'h00, iLoadByte, pack[7:0]};
      default: wordData = {iLoadByte, pack};
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst || iLoadStart) begin
      lane      <= '0;
      pack      <= '0;
      wordCount <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      if (wordEnd) begin
        lane <= '0;
        // Bytes past capacity are still accepted so the host never stalls.
        if (full) overflow  <= 1'b1;
        else      wordCount <= wordCount + (IDX_W+1)'(1);
      end else begin
        lane <= lane + 2'd1;
        if (lane == 2'd0) pack[7:0]  <= iLoadByte;
        else              pack[15:8] <= iLoadByte;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (memWe && !irst) mem[wordCount[IDX_W-1:0]] <= wordData;
  end

  // --------------------------------------------------------- fetch path
  // floor(addr/3) via reciprocal multiply; exact over the 16-bit range.
  always_comb begin
    fetchIdx = 16'((33'(iInstrAddr) * 33'd43691) >> 17);
    aligned  = ((18'(fetchIdx) * 18'd3) == 18'(iInstrAddr));
    inImage  = (17'(fetchIdx) < 17'(wordCount));
  end

  // Same-edge write and read of one index returns the old word.
  always_ff @(posedge iclk) begin
    if (irst || (state != DONE)) begin
      oInstr     <= '0;
      oAddrFault <= 1'b0;
    end else if (!aligned || !inImage) begin
      oInstr     <= '0;
      oAddrFault <= 1'b1;
    end else begin
      oInstr     <= mem[fetchIdx[IDX_W-1:0]];
      oAddrFault <= 1'b0;
    end
  end

  assign oOverflow  = overflow;
  assign oWordCount = wordCount;

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge iclk) begin
    if (irst || iLoadStart) checksum <= '0;
    else if (accept)        checksum <= checksum ^ iLoadByte;
  end

  assign oChecksum = checksum;
`else
  assign oChecksum = 8'h00;
`endif

endmodule

// File: tb/tb_instr_mem_server.sv
module tb_instr_mem_server;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        iLoadStart = 1'b0;
  logic        iLoadValid = 1'b0;
  logic [7:0]  iLoadByte = '0;
  logic        iLoadLast = 1'b0;
  logic [15:0] iInstrAddr = '0;

  logic        oLoadReadyA, oCpuRunA, oAddrFaultA, oOverflowA;
  logic [23:0] oInstrA;
  logic [10:0] oWordCountA;
  logic [7:0]  oChecksumA;

  logic        oLoadReadyB, oCpuRunB, oAddrFaultB, oOverflowB;
  logic [23:0] oInstrB;
  logic [2:0]  oWordCountB;
  logic [7:0]  oChecksumB;

  always #5 iclk = ~iclk;

  instr_mem_server #(.DEPTH(1024), .IDX_W(10)) dutA (
    .iclk(iclk), .irst(irst), .iLoadStart(iLoadStart), .iLoadValid(iLoadValid),
    .iLoadByte(iLoadByte), .iLoadLast(iLoadLast), .oLoadReady(oLoadReadyA),
    .iInstrAddr(iInstrAddr), .oInstr(oInstrA), .oCpuRun(oCpuRunA),
    .oAddrFault(oAddrFaultA), .oOverflow(oOverflowA), .oWordCount(oWordCountA),
    .oChecksum(oChecksumA)
  );

  instr_mem_server #(.DEPTH(4), .IDX_W(2)) dutB (
    .iclk(iclk), .irst(irst), .iLoadStart(iLoadStart), .iLoadValid(iLoadValid),
    .iLoadByte(iLoadByte), .iLoadLast(iLoadLast), .oLoadReady(oLoadReadyB),
    .iInstrAddr(iInstrAddr), .oInstr(oInstrB), .oCpuRun(oCpuRunB),
    .oAddrFault(oAddrFaultB), .oOverflow(oOverflowB), .oWordCount(oWordCountB),
    .oChecksum(oChecksumB)
  );

  int total = 0;
  int bad = 0;

  // reference model
  logic [23:0] refA [1024];
  logic [23:0] refB [4];
  int          expWcA = 0, expWcB = 0;
  bit          running = 0;
  logic [7:0]  loadQ [$];

  typedef struct {
    logic [15:0] addr;
    logic [23:0] instr;
    logic        fault;
  } fetchVec_t;

  fetchVec_t vec [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic logic [7:0] expChecksum();
    logic [7:0] x = 8'h00;
`ifdef INSTR_MEM_CHECKSUM_EN
    foreach (loadQ[i]) x ^= loadQ[i];
`endif
    return x;
  endfunction

  // Streams loadQ after a start pulse; gaps of idle cycles up to gapMax.
  task automatic runLoad(input int gapMax);
    int n = loadQ.size();
    int nw;
    logic [23:0] w;
    iLoadStart = 1'b1;
    iLoadValid = 1'($urandom_range(0, 1));
    iLoadByte  = 8'($urandom);
    iLoadLast  = 1'b1;
    tick();
    iLoadStart = 1'b0;
    running = 0;
    chk("startCpuRunA", oCpuRunA, 0);
    chk("startReadyA", oLoadReadyA, 1);
    chk("startWcA", oWordCountA, 0);
    chk("startOvB", oOverflowB, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapMax)) begin
        iLoadValid = 1'b0;
        iLoadByte  = 8'($urandom);
        iLoadLast  = 1'($urandom);
        tick();
      end
      iLoadValid = 1'b1;
      iLoadByte  = loadQ[i];
      iLoadLast  = (i == n - 1);
      tick();
      if (i != n - 1) begin
        chk("streamReadyB", oLoadReadyB, 1);
        chk("streamCpuRunA", oCpuRunA, 0);
      end
    end
    iLoadValid = 1'b0;
    iLoadLast  = 1'b0;
    nw = (n + 2) / 3;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int k = 0; k < 3; k++)
        if (3 * wi + k < n) w |= 24'(loadQ[3 * wi + k]) << (8 * k);
      if (wi < 1024) refA[wi] = w;
      if (wi < 4) refB[wi] = w;
    end
    expWcA = (nw > 1024) ? 1024 : nw;
    expWcB = (nw > 4) ? 4 : nw;
    running = 1;
    chk("doneCpuRunA", oCpuRunA, 1);
    chk("doneCpuRunB", oCpuRunB, 1);
    chk("doneReadyA", oLoadReadyA, 0);
    chk("doneWcA", oWordCountA, 32'(expWcA));
    chk("doneWcB", oWordCountB, 32'(expWcB));
    chk("doneOvA", oOverflowA, 32'(nw > 1024));
    chk("doneOvB", oOverflowB, 32'(nw > 4));
    chk("checksumA", oChecksumA, 32'(expChecksum()));
    chk("checksumB", oChecksumB, 32'(expChecksum()));
  endtask

  task automatic fetch(input logic [15:0] a);
    int idx = int'(a) / 3;
    bit mis = (int'(a) % 3) != 0;
    logic [23:0] eA, eB;
    logic fA, fB;
    iInstrAddr = a;
    tick();
    if (!running) begin
      eA = '0; fA = 0; eB = '0; fB = 0;
    end else begin
      if (mis || idx >= expWcA) begin eA = '0; fA = 1; end
      else begin eA = refA[idx]; fA = 0; end
      if (mis || idx >= expWcB) begin eB = '0; fB = 1; end
      else begin eB = refB[idx]; fB = 0; end
    end
    chk("fetchInstrA", oInstrA, 32'(eA));
    chk("fetchFaultA", oAddrFaultA, 32'(fA));
    chk("fetchInstrB", oInstrB, 32'(eB));
    chk("fetchFaultB", oAddrFaultB, 32'(fB));
  endtask

  initial begin
    // reset
    tick();
    tick();
    irst = 1'b0;
    chk("rstInstr", oInstrA, 0);
    chk("rstCpuRun", oCpuRunA, 0);
    chk("rstFault", oAddrFaultA, 0);
    chk("rstOverflow", oOverflowA, 0);
    chk("rstWordCount", oWordCountA, 0);
    chk("rstReady", oLoadReadyA, 0);
    chk("rstChecksum", oChecksumA, 0);

    // two-word image and table-driven fetches
    loadQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    runLoad(0);
    chk("img1Wc", oWordCountA, 2);
    vec[0] = '{16'd0,     24'h030201, 1'b0};
    vec[1] = '{16'd3,     24'h060504, 1'b0};
    vec[2] = '{16'd4,     24'h000000, 1'b1};
    vec[3] = '{16'd3,     24'h060504, 1'b0};
    vec[4] = '{16'd6,     24'h000000, 1'b1};
    vec[5] = '{16'd1,     24'h000000, 1'b1};
    vec[6] = '{16'd65535, 24'h000000, 1'b1};
    for (int i = 0; i < 7; i++) begin
      iInstrAddr = vec[i].addr;
      tick();
      chk("vecInstr", oInstrA, 32'(vec[i].instr));
      chk("vecFault", oAddrFaultA, 32'(vec[i].fault));
    end

    // fetch while loading is blanked; load restarted by a second start
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    running = 0;
    chk("reloadCpuRun", oCpuRunA, 0);
    iInstrAddr = 16'd0;
    tick();
    chk("stoppedInstr", oInstrA, 0);
    chk("stoppedFault", oAddrFaultA, 0);
    loadQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    runLoad(1);
    chk("padWc", oWordCountA, 2);
    iInstrAddr = 16'd3;
    tick();
    chk("padWord", oInstrA, 32'h0000DD);
    iInstrAddr = 16'd0;
    tick();
    chk("padWord0", oInstrA, 32'hCCBBAA);
    iInstrAddr = 16'd6;
    tick();
    chk("pastEndInstr", oInstrA, 0);
    chk("pastEndFault", oAddrFaultA, 1);

    // checksum
    loadQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    runLoad(0);
`ifdef INSTR_MEM_CHECKSUM_EN
    chk("checksumConst", oChecksumA, 32'h04);
`else
    chk("checksumConst", oChecksumA, 32'h00);
`endif

    // overflow on the 4-word instance
    loadQ.delete();
    for (int i = 0; i < 15; i++) loadQ.push_back(8'(8'h10 + i));
    runLoad(0);
    chk("ovFlagB", oOverflowB, 1);
    chk("ovWcB", oWordCountB, 4);
    chk("ovFlagA", oOverflowA, 0);
    for (int a = 0; a <= 12; a += 3) fetch(16'(a));

    // reset in the middle of a load
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    running = 0;
    iLoadValid = 1'b1;
    iLoadByte = 8'h55;
    tick();
    iLoadByte = 8'h66;
    tick();
    iLoadValid = 1'b0;
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("midRstCpuRun", oCpuRunA, 0);
    chk("midRstReady", oLoadReadyA, 0);
    chk("midRstWc", oWordCountA, 0);
    fetch(16'd0);
    loadQ = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    runLoad(1);
    for (int a = 0; a <= 9; a++) fetch(16'(a));

    // randomized images and fetches
    for (int it = 0; it < 20; it++) begin
      loadQ.delete();
      repeat ($urandom_range(1, 30)) loadQ.push_back(8'($urandom));
      runLoad(2);
      for (int f = 0; f < 15; f++) begin
        if ($urandom_range(0, 1) == 1) fetch(16'(3 * $urandom_range(0, 12)));
        else fetch(16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
